// File: rtl/pipe_hazard_ctrl.sv
// Hazard/redirect controller for the 5-stage core: flush, bubble, PC stall, LSU hold and stale-fetch discard.
// Optional perf counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int CPU_WIDTH  = 64,
    parameter int LU_BUBBLES = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_exu_redirect,
    input  logic [CPU_WIDTH-1:0] i_exu_redirect_pc,
    input  logic                 i_ifu_busy,
    input  logic                 i_ifu_rsp_valid,
    input  logic                 i_lsu_busy,
    input  logic                 i_exu_load,
    input  logic [4:0]           i_exu_rd,
    input  logic [4:0]           i_idu_rs1,
    input  logic [4:0]           i_idu_rs2,
    input  logic                 i_idu_rs1_en,
    input  logic                 i_idu_rs2_en,
    output logic                 o_flush,
    output logic                 o_bubble,
    output logic                 o_pc_stall,
    output logic                 o_hold,
    output logic                 o_pc_redirect_en,
    output logic [CPU_WIDTH-1:0] o_pc_redirect,
    output logic                 o_discard,
    output logic [31:0]          o_perf_stall_cnt,
    output logic [31:0]          o_perf_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DISCARD = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [1:0] LU_RELOAD = 2'(LU_BUBBLES - 1);

    state_t     state_q, state_d;
    logic [1:0] lu_cnt_q, lu_cnt_d;
    logic       redirect_act;
    logic       lu_hazard;

    always_comb begin
        lu_hazard = i_exu_load && (i_exu_rd != 5'd0) &&
                    ((i_idu_rs1_en && (i_idu_rs1 == i_exu_rd)) ||
                     (i_idu_rs2_en && (i_idu_rs2 == i_exu_rd)));
        // EXU is frozen in MEMWAIT, so any redirect seen there is spurious.
        redirect_act = i_rst_n && i_exu_redirect && (state_q != ST_MEMWAIT);
    end

    always_comb begin
        state_d          = state_q;
        lu_cnt_d         = lu_cnt_q;
        o_flush          = 1'b0;
        o_bubble         = 1'b0;
        o_pc_stall       = 1'b0;
        o_hold           = 1'b0;
        o_pc_redirect_en = 1'b0;
        o_pc_redirect    = '0;
        o_discard        = 1'b0;
        if (redirect_act) begin
            o_flush          = 1'b1;
            o_pc_redirect_en = 1'b1;
            o_pc_redirect    = i_exu_redirect_pc;
            lu_cnt_d         = 2'd0;
            if (state_q == ST_DISCARD) begin
                o_discard = 1'b1;
                state_d   = ST_DISCARD;
            end else if (i_ifu_busy && !i_ifu_rsp_valid) begin
                state_d = ST_DISCARD;
            end else begin
                state_d = ST_RUN;
            end
        end else if (i_rst_n) begin
            unique case (state_q)
                ST_RUN: begin
                    // LSU wait outranks load-use; the counter holds until RUN resumes.
                    if (i_lsu_busy) begin
                        state_d = ST_MEMWAIT;
                    end else if (lu_cnt_q != 2'd0) begin
                        o_bubble   = 1'b1;
                        o_pc_stall = 1'b1;
                        lu_cnt_d   = lu_cnt_q - 2'd1;
                    end else if (lu_hazard) begin
                        o_bubble   = 1'b1;
                        o_pc_stall = 1'b1;
                        lu_cnt_d   = LU_RELOAD;
                    end
                end
                ST_DISCARD: begin
                    o_discard  = 1'b1;
                    o_pc_stall = 1'b1;
                    if (i_ifu_rsp_valid) begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEMWAIT: begin
                    o_hold     = 1'b1;
                    o_pc_stall = 1'b1;
                    if (!i_lsu_busy) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_RUN;
            lu_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (o_pc_stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redirect_act && (perf_flush_q != 32'hFFFF_FFFF)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign o_perf_stall_cnt = perf_stall_q;
    assign o_perf_flush_cnt = perf_flush_q;
`else
    assign o_perf_stall_cnt = 32'd0;
    assign o_perf_flush_cnt = 32'd0;
`endif

endmodule
